// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam int DEFAULT_BURST_LEN = 4;
  localparam int BYTE_OFFSET       = 2;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one cache-line burst: counts on enable, flags the last
// beat, and clears synchronously.
module burst_counter #(
  parameter int LEN = 4,
  parameter int W   = $clog2(LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto one memory port.
// Optional macro ROUND_ROBIN_EN replaces fixed D-over-I priority with alternation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ic_req,
  input  logic [ADDR_WIDTH-1:0]         ic_addr,
  output logic                          ic_rvalid,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_WIDTH-1:0]         dc_addr,
  input  logic [DATA_WIDTH-1:0]         dc_wdata,
  output logic                          dc_rvalid,
  output logic                          dc_done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(BURST_LEN)-1:0]  beat_idx,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_ready,
  output logic                          stall_f,
  output logic                          stall_m
);

  localparam int CNT_W     = $clog2(BURST_LEN);
  localparam int LINE_BITS = CNT_W + BYTE_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ADDR_WIDTH'((64'd1 << LINE_BITS) - 64'd1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    grant_i, grant_d;
  logic                    beat_fire, last_beat, tc;
  logic                    pick_d;

  assign grant_i = (state_q == GNT_I);
  assign grant_d = (state_q == GNT_D);

  // A burst being reset produces no beat and no done pulse.
  assign beat_fire = (state_q != IDLE) && mem_ready && rst_n;
  assign last_beat = beat_fire && tc;

`ifdef ROUND_ROBIN_EN
  logic prefer_i_q, prefer_i_d;

  assign pick_d = dc_req && (!ic_req || !prefer_i_q);

  always_comb begin
    prefer_i_d = prefer_i_q;
    if (last_beat) begin
      prefer_i_d = grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prefer_i_q <= 1'b1;
    end else begin
      prefer_i_q <= prefer_i_d;
    end
  end
`else
  assign pick_d = dc_req;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = GNT_D;
          base_d  = dc_addr & ~LINE_MASK;
        end else if (ic_req) begin
          state_d = GNT_I;
          base_d  = ic_addr & ~LINE_MASK;
        end
      end
      GNT_I, GNT_D: begin
        if (last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  burst_counter #(
    .LEN (BURST_LEN),
    .W   (CNT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == IDLE),
    .en_i  (beat_fire),
    .cnt_o (beat_idx),
    .tc_o  (tc)
  );

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = grant_d && dc_we;
  assign mem_addr  = base_q + (ADDR_WIDTH'(beat_idx) << BYTE_OFFSET);
  assign mem_wdata = mem_we ? dc_wdata : '0;

  assign ic_rvalid = grant_i && beat_fire;
  assign dc_rvalid = grant_d && beat_fire && !dc_we;
  assign ic_done   = grant_i && last_beat;
  assign dc_done   = grant_d && last_beat;

  assign stall_f = ic_req && !ic_done;
  assign stall_m = dc_req && !dc_done;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a line-level model queues expected beats,
// a negedge monitor compares every memory beat the DUT presents.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk, rst_n;
  logic          ic_req, ic_rvalid, ic_done;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic          dc_req, dc_we, dc_rvalid, dc_done;
  logic [DW-1:0] dc_wdata, rdata, mem_wdata, mem_rdata;
  logic [1:0]    beat_idx;
  logic          mem_req, mem_we, mem_ready;
  logic          stall_f, stall_m;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .rdata(rdata), .beat_idx(beat_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  logic [DW-1:0] wline [BL];
  assign dc_wdata  = wline[beat_idx];
  assign mem_rdata = mem_fn(mem_addr);

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          idx;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    prefer_i = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a line transfer is BURST_LEN word beats from the aligned base.
  task automatic push_line(input bit is_d, input bit we, input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'(BL * 4 - 1);
    for (int i = 0; i < BL; i++) begin
      beat_t b;
      b.is_d  = is_d;
      b.we    = we;
      b.addr  = base + 32'(4 * i);
      b.wdata = we ? wline[i] : 32'h0;
      b.idx   = i;
      b.last  = (i == BL - 1);
      exp_q.push_back(b);
    end
    prefer_i = is_d;
  endtask

  // mem_ready generator: 0 always, 1 random, 2 three waits per beat, 3 forced.
  int   ready_mode = 3;
  int   wcnt = 0;
  logic force_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = 1'($urandom_range(0, 1));
      2: begin
        if (!mem_req) begin
          mem_ready = 1'b0;
          wcnt = 0;
        end else if (wcnt == 3) begin
          mem_ready = 1'b1;
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end
      default: mem_ready = force_ready;
    endcase
  end

  // Monitor
  bit          mon_en = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  bit          gap_arm = 1'b0;
  int          gap = 0;
  int          ic_beats = 0;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("stall_f", stall_f, ic_req & ~ic_done);
      check("stall_m", stall_m, dc_req & ~dc_done);
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("beat_idx", beat_idx, e.idx);
          check("mem_we", mem_we, e.we);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          else      check("rdata", rdata, mem_fn(e.addr));
          check("ic_rvalid", ic_rvalid, !e.is_d);
          check("dc_rvalid", dc_rvalid, e.is_d && !e.we);
          check("ic_done", ic_done, !e.is_d && e.last);
          check("dc_done", dc_done, e.is_d && e.last);
        end
      end else if (!mem_req) begin
        check("idle_quiet", {ic_rvalid, dc_rvalid, ic_done, dc_done, mem_we}, 0);
        check("idle_beat_idx", beat_idx, 0);
      end
      if (mem_req && prev_wait) begin
        check("addr_stable", mem_addr, prev_addr);
        check("wdata_stable", mem_wdata, prev_wdata);
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (gap_arm) begin
        if (mem_req) begin
          check("one_idle_gap", gap, 1);
          gap_arm = 1'b0;
        end else begin
          gap++;
        end
      end
      if (ic_done) begin
        gap_arm = dc_req;
        gap = 0;
      end else if (dc_done) begin
        gap_arm = ic_req;
        gap = 0;
      end
      if (ic_rvalid) ic_beats++;
    end else begin
      prev_wait = 1'b0;
      gap_arm   = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one or two line requests, model their order, and hold each until done.
  task automatic xfer(input bit do_i, input bit do_d, input bit we,
                      input logic [31:0] ia, input logic [31:0] da);
    bit i_busy, d_busy, i_fin, d_fin;
    int cyc = 0;
    for (int i = 0; i < BL; i++) wline[i] = $urandom;
    if (do_i && do_d) begin
      if (RR && prefer_i) begin
        push_line(1'b0, 1'b0, ia);
        push_line(1'b1, we, da);
      end else begin
        push_line(1'b1, we, da);
        push_line(1'b0, 1'b0, ia);
      end
    end else if (do_i) begin
      push_line(1'b0, 1'b0, ia);
    end else if (do_d) begin
      push_line(1'b1, we, da);
    end
    ic_addr = ia;
    dc_addr = da;
    dc_we   = we;
    ic_req  = do_i;
    dc_req  = do_d;
    i_busy  = do_i;
    d_busy  = do_d;
    while ((i_busy || d_busy) && cyc < 400) begin
      @(negedge clk);
      i_fin = ic_done;
      d_fin = dc_done;
      sync();
      if (i_fin) begin ic_req = 1'b0; i_busy = 1'b0; end
      if (d_fin) begin dc_req = 1'b0; d_busy = 1'b0; end
      cyc++;
    end
    if (i_busy || d_busy) begin
      check("xfer_timeout", 1, 0);
      ic_req = 1'b0;
      dc_req = 1'b0;
      exp_q.delete();
    end
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0;
    mem_ready = 1'b0;
    for (int i = 0; i < BL; i++) wline[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_flags", {ic_rvalid, dc_rvalid, ic_done, dc_done}, 0);
    sync();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    sync();

    // I refill at 0x1234 with mem_ready every cycle.
    ready_mode = 0;
    xfer(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0);
    @(negedge clk);
    check("s1_stall_f_after", stall_f, 0);
    check("s1_ic_beats", ic_beats, 4);
    sync();

    // Simultaneous read requests: priority decides order, one idle cycle between.
    xfer(1'b1, 1'b1, 1'b0, 32'h4000, 32'h8010);
    // D served last, then a simultaneous pair again.
    xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'h9000);
    xfer(1'b1, 1'b1, 1'b0, 32'h5004, 32'hA008);

    // Writeback at 0x80 with three wait cycles per beat.
    ready_mode = 2;
    xfer(1'b0, 1'b1, 1'b1, 32'h0, 32'h80);

    // Reset during beat 2 of an I burst.
    ready_mode = 0;
    mon_en = 1'b0;
    ic_addr = 32'h2000;
    ic_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (mem_req && beat_idx == 2'd2) found = 1'b1;
    end
    check("rst_burst_reached", found, 1);
    rst_n = 1'b0;
    sync();
    ic_req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_beat_idx", beat_idx, 0);
    check("mid_rst_ic_done", ic_done, 0);
    sync();
    rst_n = 1'b1;
    prefer_i = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    sync();

    // mem_ready pulses while idle must be ignored.
    ready_mode = 3;
    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_rvalid", {ic_rvalid, dc_rvalid}, 0);
      check("idle_ready_beat_idx", beat_idx, 0);
      check("idle_ready_mem_req", mem_req, 0);
    end
    force_ready = 1'b0;
    sync();

    // Randomized traffic with random memory latency.
    ready_mode = 1;
    repeat (25) begin
      int k;
      k = $urandom_range(0, 2);
      xfer(k != 1, k != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    ready_mode = 3;
    repeat (3) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
